// File: rtl/comb3_sweep_pkg.sv
// Shared types for the 3-input combinational sweep controller.
// State encoding and the default vector width.
package comb3_sweep_pkg;

  localparam int N_INPUTS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

endpackage

// File: rtl/comb3_sweep_ctrl_if.sv
// Control-side bundle of the sweep controller: start/abort
// and expected table in, status and captured table out.
interface comb3_sweep_ctrl_if
  import comb3_sweep_pkg::*;
#(
  parameter int N_INPUTS = N_INPUTS_DEF
) ();

  localparam int TABLE_W = 2 ** N_INPUTS;

  logic                start;
  logic                abort;
  logic [TABLE_W-1:0]  expected;
  logic                busy;
  logic                done;
  logic [TABLE_W-1:0]  table_out;
  logic                pass;
  logic [N_INPUTS-1:0] fail_idx;

  modport master (
    output start,
    output abort,
    output expected,
    input  busy,
    input  done,
    input  table_out,
    input  pass,
    input  fail_idx
  );

  modport slave (
    input  start,
    input  abort,
    input  expected,
    output busy,
    output done,
    output table_out,
    output pass,
    output fail_idx
  );

endinterface

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder with an any-bit flag.
// Index is 0 when no bit is set.
module lsb_priority_enc #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_in,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan downward so the lowest set bit is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_in[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/comb3_sweep_ctrl.sv
// Walks a small combinational unit through every input vector,
// captures y into a truth table and grades it against expected.
module comb3_sweep_ctrl
  import comb3_sweep_pkg::*;
#(
  parameter int N_INPUTS      = N_INPUTS_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  comb3_sweep_ctrl_if.slave   ctl,
  output logic [N_INPUTS-1:0] vec,
  input  logic                y_in
);

  localparam int TABLE_W = 2 ** N_INPUTS;
  localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST = '1;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]    cnt_q;
  logic [N_INPUTS-1:0] vec_q;
  logic [TABLE_W-1:0]  tab_q;
  logic [TABLE_W-1:0]  exp_q;
  logic                pass_q;
  logic [N_INPUTS-1:0] idx_q;

  logic                hold_end;
  logic                last_vec;
  logic [TABLE_W-1:0]  tab_cap;
  logic [TABLE_W-1:0]  mism;
  logic [N_INPUTS-1:0] enc_idx;
  logic                enc_any;

  assign hold_end = (cnt_q == CNT_LAST);
  assign last_vec = (vec_q == VEC_LAST);

  // Table as it will look once the current vector is captured,
  // so the grade is ready in the same cycle done pulses.
  always_comb begin
    tab_cap        = tab_q;
    tab_cap[vec_q] = y_in;
  end

  assign mism = tab_cap ^ exp_q;

  lsb_priority_enc #(
    .W  (TABLE_W),
    .IW (N_INPUTS)
  ) u_enc (
    .vec_in (mism),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ctl.start) state_d = APPLY;
      end
      APPLY: begin
        if (ctl.abort)
          state_d = IDLE;
        else if (hold_end && last_vec)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      tab_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (ctl.start) begin
            cnt_q  <= '0;
            vec_q  <= '0;
            tab_q  <= '0;
            exp_q  <= ctl.expected;
            pass_q <= 1'b0;
            idx_q  <= '0;
          end
        end
        APPLY: begin
          if (ctl.abort) begin
            cnt_q <= '0;
            vec_q <= '0;
          end else if (hold_end) begin
            cnt_q <= '0;
            tab_q <= tab_cap;
            if (last_vec) begin
              vec_q  <= '0;
              pass_q <= ~enc_any;
              idx_q  <= enc_idx;
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          vec_q <= '0;
          cnt_q <= '0;
        end
        default: begin
          vec_q <= '0;
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign vec           = vec_q;
  assign ctl.busy      = (state_q == APPLY);
  assign ctl.done      = (state_q == DONE);
  assign ctl.table_out = tab_q;
  assign ctl.pass      = pass_q;
  assign ctl.fail_idx  = idx_q;

endmodule

// File: doc/comb3_sweep_ctrl.md
Name: comb3_sweep_ctrl

Overview:
Sequencer that drives a small combinational logic unit (3 inputs a/b/c, 1 output y) through every input combination, holding each vector for a programmable settle time, and captures the output into a truth-table register. At completion it compares the captured table against an expected table and reports pass/fail with the lowest failing index. It sits between a start/done control source (bench or front panel) and the combinational unit under test.

Parameters:
N_INPUTS, 3, width of the input vector driven to the unit; TABLE_W = 2**N_INPUTS (localparam)
SETTLE_CYCLES, 2, clock cycles each vector is held before y is sampled; must be >= 1

Ports:
clk  in  1  single system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a sweep; accepted only in IDLE
abort  in  1  synchronous cancel of a sweep in progress
expected  in  TABLE_W  expected truth table, bit i = y for vec==i; latched on accepted start
vec  out  N_INPUTS  drives the unit: a=vec[2], b=vec[1], c=vec[0]
y_in  in  1  unit output, sampled
busy  out  1  high while sweeping (APPLY state)
done  out  1  one-cycle pulse at sweep completion
table_out  out  TABLE_W  captured truth table
pass  out  1  table_out == expected latch, valid from done onward
fail_idx  out  N_INPUTS  lowest index i where table_out[i] != expected[i]; 0 when pass

Behaviour:
- Reset (async, immediate): state=IDLE, vec=0, busy=0, done=0, table_out=0, pass=0, fail_idx=0, counter=0, expected latch=0.
- States: IDLE, APPLY, DONE.
- IDLE: start=1 -> APPLY; same edge: vec<=0, cnt<=0, table_out<=0, pass<=0, fail_idx<=0, expected latched. busy=1 from next cycle.
- APPLY: cnt increments each cycle; when cnt==SETTLE_CYCLES-1, table_out[vec]<=y_in on that edge, cnt<=0; if vec==TABLE_W-1 -> DONE, else vec<=vec+1.
- Each vector is held exactly SETTLE_CYCLES cycles; y sampled at the end of the last hold cycle.
- DONE: done=1 for this cycle only; busy=0; pass/fail_idx registered from final table_out vs. expected latch; -> IDLE unconditionally. vec returns to 0.
- Latency: start sampled at edge 0 -> APPLY in cycles 1..TABLE_W*SETTLE_CYCLES -> done high in cycle TABLE_W*SETTLE_CYCLES+1.
- start while APPLY or DONE: ignored, no queuing. start held high: restarts at the first IDLE cycle, giving period TABLE_W*SETTLE_CYCLES+2.
- abort in APPLY: -> IDLE next edge, busy=0, no done pulse, vec<=0, table_out keeps partial captures, pass stays 0. abort outside APPLY: ignored. abort and start together in IDLE: start wins (abort ignored).
- Counter width $clog2(SETTLE_CYCLES+1); vec increment never wraps inside a sweep.
- rst mid-sweep: all outputs return to reset values immediately, with no done pulse.

Decomposition:
- Package comb3_sweep_pkg: state enum typedef (IDLE, APPLY, DONE), default N_INPUTS constant.
- One sub-module, lsb_priority_enc: input TABLE_W mismatch vector (table_out ^ expected), output index of the lowest set bit plus an any flag; fail_idx and pass derive from it.

Test Plan:
1. SETTLE=2, stub y=a&b&c, expected=8'h80, start pulse at cycle 0 -> busy cycles 1..16, done only in cycle 17, table_out=8'h80, pass=1, fail_idx=0.
2. Stub y=c, expected=8'hAA -> table_out=8'hAA, pass=1; rerun with expected=8'hAE -> pass=0, fail_idx=2.
3. start re-pulsed at cycles 5 and 17 -> ignored; exactly one done at cycle 17; vec sequence 0..7, each held 2 cycles.
4. abort at cycle 7 -> busy=0 from cycle 8, no done; table_out holds bits 0..2 captured; new start then completes normally with done 17 cycles later.
5. rst asserted asynchronously mid-cycle at cycle 9 -> vec, busy, table_out, and pass drop to 0 before the next edge; no done follows.
6. SETTLE=1, start held high, stub y=a^b^c -> done in cycles 9, 19, 29; table_out=8'h96 and pass=1 each time, with expected=8'h96.
